phased_delay_array: RTL and testbench

PHASED_DELAY_ARRAY -- requirements
Module: phased_delay_array

---
 rtl/phased_delay_array_if.sv | 16 +
 rtl/phased_delay_array.sv | 92 +++++++++
 tb/tb_phased_delay_array.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/phased_delay_array_if.sv
// phased_delay_array_if: source waveform, configuration handshake and delayed outputs.
interface phased_delay_array_if #(
    parameter int CHANNELS = 20,
    parameter int STEP_W   = 14
);
    logic                pwm_in;
    logic                cfg_valid;
    logic [STEP_W-1:0]   cfg_step;
    logic                cfg_dir;
    logic                cfg_ready;
    logic [CHANNELS-1:0] signal;
    logic                busy;
    logic                overflow;
    modport master (output pwm_in, cfg_valid, cfg_step, cfg_dir, input cfg_ready, signal, busy, overflow);
    modport slave  (input pwm_in, cfg_valid, cfg_step, cfg_dir, output cfg_ready, signal, busy, overflow);
endinterface

// File: rtl/phased_delay_array.sv
// phased_delay_array: replays timestamped edges of pwm_in on CHANNELS outputs with linearly graded delays.
module phased_delay_array #(
    parameter int CHANNELS     = 20,
    parameter int TS_W         = 16,
    parameter int STEP_W       = 14,
    parameter int EDGE_DEPTH   = 16,
    parameter int DEFAULT_STEP = 430
) (
    input logic                 clk,
    input logic                 rst,
    phased_delay_array_if.slave bus
);
    localparam int AW       = $clog2(EDGE_DEPTH);
    localparam int PW       = AW + 1;
    localparam int STEP_MAX = ((1 << (TS_W - 1)) - 1) / (CHANNELS - 1);
    localparam int STEP_RST = DEFAULT_STEP > STEP_MAX ? STEP_MAX : DEFAULT_STEP;
    localparam int CW       = (TS_W > STEP_W + 5 ? TS_W : STEP_W + 5) + 1;

    logic [1:0]          sync_q;
    logic                lvl_q;
    logic [TS_W-1:0]     now_q;
    logic [PW-1:0]       wr_q;
    logic [PW-1:0]       rd_q [CHANNELS];
    logic [PW-1:0]       rd_d [CHANNELS];
    logic [STEP_W-1:0]   step_q, step_d;
    logic                dir_q, acc_q, ovf_q;
    logic [CHANNELS-1:0] sig_q, sig_d, pop;
    logic [TS_W-1:0]     ts_mem [EDGE_DEPTH];
    logic                lvl_mem [EDGE_DEPTH];
    logic                accept, edge_det, pop_max, full, push;
    logic [PW-1:0]       occ;

    assign accept   = bus.cfg_valid && !acc_q;
    assign edge_det = sync_q[1] != lvl_q;
    assign step_d   = CW'(bus.cfg_step) > CW'(STEP_MAX) ? STEP_W'(STEP_MAX) : bus.cfg_step;
    // the most-delayed channel is the last reader, so it alone defines free space
    assign pop_max  = dir_q ? pop[0] : pop[CHANNELS-1];
    assign occ      = wr_q - (dir_q ? rd_q[0] : rd_q[CHANNELS-1]);
    assign full     = occ == PW'(EDGE_DEPTH) && !pop_max;
    assign push     = edge_det && (accept || !full);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [CW-1:0]   dly;
        logic [TS_W-1:0] age;
        assign dly      = CW'(dir_q ? CHANNELS - 1 - k : k) * CW'(step_q);
        assign age      = now_q - ts_mem[rd_q[k][AW-1:0]];
        assign pop[k]   = rd_q[k] != wr_q && CW'(age) >= dly;
        assign rd_d[k]  = accept ? wr_q : rd_q[k] + PW'(pop[k]);
        assign sig_d[k] = accept ? sync_q[1] : pop[k] ? lvl_mem[rd_q[k][AW-1:0]] : sig_q[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            now_q  <= '0;
            wr_q   <= '0;
            step_q <= STEP_W'(STEP_RST);
            dir_q  <= 1'b0;
            acc_q  <= 1'b0;
            ovf_q  <= 1'b0;
            sig_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) rd_q[i] <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.pwm_in};
            lvl_q  <= sync_q[1];
            now_q  <= now_q + 1'b1;
            wr_q   <= wr_q + PW'(push);
            acc_q  <= accept;
            ovf_q  <= !accept && (ovf_q || (edge_det && full));
            sig_q  <= sig_d;
            for (int i = 0; i < CHANNELS; i++) rd_q[i] <= rd_d[i];
            if (accept) begin
                step_q <= step_d;
                dir_q  <= bus.cfg_dir;
            end
        end
    end

    // timestamp is the counter value after the write edge, so age 0 means "written last edge"
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_q[AW-1:0]]  <= now_q + 1'b1;
            lvl_mem[wr_q[AW-1:0]] <= sync_q[1];
        end
    end

    assign bus.signal    = sig_q;
    assign bus.busy      = occ != '0;
    assign bus.overflow  = ovf_q;
    assign bus.cfg_ready = !acc_q;
endmodule

// File: tb/tb_phased_delay_array.sv
// tb_phased_delay_array: directed vectors for delays, wrap, overflow, flush and reset behaviour.
module tb_phased_delay_array;
    localparam int CH = 4;

    typedef struct {
        logic cfg;
        int   step;
        logic dir;
        int   d0, d1, d2, d3;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   r = 0;
    int   tog [CH];
    logic [CH-1:0] prev = '0;
    vec_t vecs [8];

    phased_delay_array_if #(.CHANNELS(CH), .STEP_W(14)) bus ();

    phased_delay_array #(
        .CHANNELS(CH), .TS_W(8), .STEP_W(14), .EDGE_DEPTH(4), .DEFAULT_STEP(430)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int k = 0; k < CH; k++) tog[k] = 0;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < CH; k++) if (bus.signal[k] != prev[k]) tog[k]++;
        prev = bus.signal;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_cfg(input int step, input logic dir);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_step  = 14'(step);
        bus.cfg_dir   = dir;
        @(negedge clk);
        check("cfg_ready after accept", int'(bus.cfg_ready), 0);
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        check("cfg_ready recovers", int'(bus.cfg_ready), 1);
    endtask

    task automatic measure(input string tag, input logic lvl, input int e0, input int e1, input int e2, input int e3);
        int exp [CH];
        int got [CH];
        int n;
        bit done;
        exp = '{e0, e1, e2, e3};
        for (int k = 0; k < CH; k++) got[k] = -1;
        @(negedge clk);
        bus.pwm_in = lvl;
        n = cyc + 1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            done = 1'b1;
            for (int k = 0; k < CH; k++) begin
                if (got[k] < 0 && bus.signal[k] == lvl) got[k] = cyc - n - 3;
                if (got[k] < 0) done = 1'b0;
            end
            if (done) break;
        end
        for (int k = 0; k < CH; k++) check($sformatf("%s lvl%0d ch%0d delay", tag, lvl, k), got[k], exp[k]);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (bus.busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({tag, " idle"}, int'(bus.busy), 0);
    endtask

    initial begin
        int base [CH];
        vecs[0] = '{1'b0, 0,    1'b0, 0,   42,  84, 126};
        vecs[1] = '{1'b1, 10,   1'b0, 0,   10,  20, 30};
        vecs[2] = '{1'b1, 10,   1'b1, 30,  20,  10, 0};
        vecs[3] = '{1'b1, 40,   1'b0, 0,   40,  80, 120};
        vecs[4] = '{1'b1, 100,  1'b0, 0,   42,  84, 126};
        vecs[5] = '{1'b1, 0,    1'b1, 0,   0,   0,  0};
        vecs[6] = '{1'b1, 7,    1'b1, 21,  14,  7,  0};
        vecs[7] = '{1'b1, 1000, 1'b1, 126, 84,  42, 0};

        bus.pwm_in = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_step = '0;
        bus.cfg_dir = 1'b0;
        repeat (3) @(negedge clk);
        check("reset signal", int'(bus.signal), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset overflow", int'(bus.overflow), 0);
        check("reset cfg_ready", int'(bus.cfg_ready), 1);
        r = cyc;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].cfg) apply_cfg(vecs[i].step, vecs[i].dir);
            measure($sformatf("vec%0d", i), 1'b1, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
            measure($sformatf("vec%0d", i), 1'b0, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
            wait_idle($sformatf("vec%0d", i));
        end

        // entry timestamp lands on 250 so the age computation crosses the counter wrap
        apply_cfg(40, 1'b0);
        while (((cyc + 2 - r) % 256) != 248) @(negedge clk);
        measure("wrap", 1'b1, 0, 40, 80, 120);
        measure("wrap", 1'b0, 0, 40, 80, 120);
        wait_idle("wrap");

        // edge in flight during the accept cycle becomes the first entry of the new setup
        @(negedge clk);
        bus.pwm_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_step = 14'd10;
        bus.cfg_dir = 1'b0;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("accept edge busy", int'(bus.busy), 1);
        check("accept edge signal", int'(bus.signal), 15);
        wait_idle("accept edge");
        check("accept edge hold", int'(bus.signal), 15);
        measure("after flush", 1'b0, 0, 10, 20, 30);
        wait_idle("after flush");

        apply_cfg(1000, 1'b0);
        for (int k = 0; k < CH; k++) base[k] = tog[k];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.pwm_in = ~bus.pwm_in;
            repeat (9) @(negedge clk);
        end
        check("overflow set", int'(bus.overflow), 1);
        repeat (200) @(negedge clk);
        for (int k = 0; k < CH; k++) check($sformatf("overflow ch%0d toggles", k), tog[k] - base[k], 4);
        check("overflow final signal", int'(bus.signal), 0);
        check("overflow sticky", int'(bus.overflow), 1);
        check("overflow drained", int'(bus.busy), 0);
        apply_cfg(10, 1'b0);
        check("overflow cleared", int'(bus.overflow), 0);
        check("accept loads level", int'(bus.signal), 15);
        measure("post overflow", 1'b0, 0, 10, 20, 30);
        wait_idle("post overflow");

        // a free and a push in the same cycle at full must not drop the push
        apply_cfg(1, 1'b0);
        for (int k = 0; k < CH; k++) base[k] = tog[k];
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.pwm_in = ~bus.pwm_in;
        end
        repeat (30) @(negedge clk);
        check("stream overflow", int'(bus.overflow), 0);
        for (int k = 0; k < CH; k++) check($sformatf("stream ch%0d toggles", k), tog[k] - base[k], 12);
        check("stream final signal", int'(bus.signal), 0);
        check("stream busy", int'(bus.busy), 0);

        apply_cfg(42, 1'b0);
        @(negedge clk);
        bus.pwm_in = 1'b1;
        repeat (20) @(negedge clk);
        check("pre reset busy", int'(bus.busy), 1);
        check("pre reset signal", int'(bus.signal), 1);
        bus.pwm_in = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_step = 14'd5;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.cfg_valid = 1'b0;
        check("mid reset signal", int'(bus.signal), 0);
        check("mid reset busy", int'(bus.busy), 0);
        check("mid reset overflow", int'(bus.overflow), 0);
        check("mid reset cfg_ready", int'(bus.cfg_ready), 1);
        for (int k = 0; k < CH; k++) base[k] = tog[k];
        repeat (260) @(negedge clk);
        for (int k = 0; k < CH; k++) check($sformatf("quiet ch%0d toggles", k), tog[k] - base[k], 0);
        check("quiet busy", int'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
